// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch sequencer: PC unit opcodes and fetch FSM states.
// The PC unit sits beside the fetch unit and consumes pc_op directly.
package fetch_unit_pkg;

    localparam logic [1:0] PCU_OP_NOP    = 2'd0;
    localparam logic [1:0] PCU_OP_INC    = 2'd1;
    localparam logic [1:0] PCU_OP_ASSIGN = 2'd2;
    localparam logic [1:0] PCU_OP_RESET  = 2'd3;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_OUT  = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of PC, instruction-memory, decoder and redirect signals around the fetch unit.
// master = fetch unit side, slave = surrounding CPU (PC unit, memory, decode/execute).
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pc_cur;
    logic [1:0]        pc_op;
    logic [ADDR_W-1:0] pc_target;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_ack;
    logic [DATA_W-1:0] mem_rd_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halt;

    modport master (
        input  pc_cur, mem_rd_ack, mem_rd_data, instr_ready,
               branch_taken, branch_target, halt,
        output pc_op, pc_target, mem_rd_req, mem_addr,
               instr, instr_pc, instr_valid
    );

    modport slave (
        output pc_cur, mem_rd_ack, mem_rd_data, instr_ready,
               branch_taken, branch_target, halt,
        input  pc_op, pc_target, mem_rd_req, mem_addr,
               instr, instr_pc, instr_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: requests the word at the current PC, holds it for the
// decoder until accepted, and steers the PC unit (inc / branch redirect / reset).
//
// state  | meaning
// S_REQ  | read request outstanding at mem_addr = pc_cur
// S_OUT  | fetched word presented to decoder, waiting for instr_ready
// S_HALT | fetching stopped until reset
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              capture;
    logic [1:0]        pc_op;
    logic              mem_rd_req;
    logic              instr_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // halt outranks branch, which outranks the normal handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else if (!bus.branch_taken && bus.mem_rd_ack) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.halt) begin
                    state_d = S_HALT;
                end else if (bus.branch_taken || bus.instr_ready) begin
                    state_d = S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_op       = PCU_OP_NOP;
        mem_rd_req  = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        if (reset) begin
            pc_op = PCU_OP_RESET;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    mem_rd_req = 1'b1;
                    if (!bus.halt) begin
                        if (bus.branch_taken) begin
                            pc_op = PCU_OP_ASSIGN;
                        end else if (bus.mem_rd_ack) begin
                            pc_op   = PCU_OP_INC;
                            capture = 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    instr_valid = 1'b1;
                    if (!bus.halt && bus.branch_taken) begin
                        pc_op = PCU_OP_ASSIGN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else if (capture) begin
            instr_q    <= bus.mem_rd_data;
            instr_pc_q <= bus.pc_cur;
        end
    end

    assign bus.pc_op       = pc_op;
    assign bus.pc_target   = bus.branch_target;
    assign bus.mem_rd_req  = mem_rd_req;
    assign bus.mem_addr    = bus.pc_cur;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a PC unit and memory around the DUT, a cycle model
// of the fetch protocol, and a scoreboard of fetched words checked when the decoder sees them.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PH_FETCH   = 0;
    localparam int PH_PRESENT = 1;
    localparam int PH_HALTED  = 2;

    typedef struct {
        logic [15:0] data;
        logic [15:0] pc;
    } item_t;

    logic clk;
    logic reset;
    logic [15:0] pc_reg;
    logic [15:0] rnd_word;
    logic        rnd_mode;
    int n_checks = 0;
    int n_pass   = 0;

    item_t sb[$];
    item_t cur;
    logic  fresh = 1'b1;

    int          phase = PH_FETCH;
    logic [15:0] mpc   = 16'h0000;
    logic [1:0]  eop;
    logic        ereq, eval;

    fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) pcif ();

    fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pcif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC unit and memory of the surrounding CPU
    assign pcif.pc_cur      = pc_reg;
    assign pcif.mem_rd_data = rnd_mode ? rnd_word : 16'h1000 + pcif.mem_addr;

    initial pc_reg = 16'h0000;
    always @(posedge clk) begin
        case (pcif.pc_op)
            PCU_OP_RESET:  pc_reg <= 16'h0000;
            PCU_OP_INC:    pc_reg <= pc_reg + 16'd1;
            PCU_OP_ASSIGN: pc_reg <= pcif.pc_target;
            default:       pc_reg <= pc_reg;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: what the protocol requires this cycle, then where it goes next.
    always @(negedge clk) begin
        eop  = PCU_OP_NOP;
        ereq = 1'b0;
        eval = 1'b0;
        if (reset) eop = PCU_OP_RESET;
        else if (phase == PH_FETCH) begin
            ereq = 1'b1;
            if (pcif.halt)              eop = PCU_OP_NOP;
            else if (pcif.branch_taken) eop = PCU_OP_ASSIGN;
            else if (pcif.mem_rd_ack)   eop = PCU_OP_INC;
        end else if (phase == PH_PRESENT) begin
            eval = 1'b1;
            if (!pcif.halt && pcif.branch_taken) eop = PCU_OP_ASSIGN;
        end
        chk("pc_op", 32'(pcif.pc_op), 32'(eop));
        chk("mem_rd_req", 32'(pcif.mem_rd_req), 32'(ereq));
        chk("instr_valid", 32'(pcif.instr_valid), 32'(eval));
        chk("mem_addr", 32'(pcif.mem_addr), 32'(mpc));
        chk("pc_target", 32'(pcif.pc_target), 32'(pcif.branch_target));

        if (reset) begin
            phase = PH_FETCH;
            mpc   = 16'h0000;
            sb.delete();
        end else if (pcif.halt) begin
            phase = PH_HALTED;
        end else if (phase == PH_FETCH) begin
            if (pcif.branch_taken) mpc = pcif.branch_target;
            else if (pcif.mem_rd_ack) begin
                sb.push_back('{data: pcif.mem_rd_data, pc: mpc});
                mpc   = mpc + 16'd1;
                phase = PH_PRESENT;
            end
        end else if (phase == PH_PRESENT) begin
            if (pcif.branch_taken) begin
                mpc   = pcif.branch_target;
                phase = PH_FETCH;
            end else if (pcif.instr_ready) begin
                phase = PH_FETCH;
            end
        end
    end

    // Monitor: each new presentation pops one expected word, which must stay stable while held
    always @(negedge clk) begin
        if (pcif.instr_valid === 1'b1) begin
            if (fresh) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_empty instr=%h instr_pc=%h with nothing fetched", pcif.instr, pcif.instr_pc);
                end else begin
                    cur = sb.pop_front();
                end
                fresh = 1'b0;
            end
            chk("instr", 32'(pcif.instr), 32'(cur.data));
            chk("instr_pc", 32'(pcif.instr_pc), 32'(cur.pc));
        end else begin
            fresh = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rnd_word = 16'($urandom);
    endtask

    task automatic idle();
        pcif.mem_rd_ack    = 1'b0;
        pcif.instr_ready   = 1'b0;
        pcif.branch_taken  = 1'b0;
        pcif.branch_target = 16'h0000;
        pcif.halt          = 1'b0;
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (pcif.instr_valid !== 1'b1 && n < lim) begin
            pcif.mem_rd_ack  = 1'b1;
            pcif.instr_ready = 1'b0;
            tick();
            n++;
        end
        if (n == lim) begin
            n_checks++;
            $display("FAIL wait_valid timeout actual=0 required=1");
        end
    endtask

    task automatic wait_req(input int lim);
        int n = 0;
        while (pcif.mem_rd_req !== 1'b1 && n < lim) begin
            pcif.mem_rd_ack  = 1'b0;
            pcif.instr_ready = 1'b1;
            tick();
            n++;
        end
        if (n == lim) begin
            n_checks++;
            $display("FAIL wait_req timeout actual=0 required=1");
        end
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        rnd_mode = 1'b0;
        rnd_word = 16'h0000;
        idle();
        repeat (3) tick();
        chk("reset_instr", 32'(pcif.instr), 32'h0);
        chk("reset_instr_pc", 32'(pcif.instr_pc), 32'h0);

        // zero-wait memory, decoder always ready
        reset            = 1'b0;
        pcif.mem_rd_ack  = 1'b1;
        pcif.instr_ready = 1'b1;
        repeat (12) tick();

        // three wait cycles per fetch
        w = 0;
        repeat (20) begin
            if (pcif.mem_rd_req === 1'b1) begin
                pcif.mem_rd_ack = (w == 3);
                w = (w == 3) ? 0 : w + 1;
            end else begin
                pcif.mem_rd_ack = 1'b0;
                w = 0;
            end
            tick();
        end

        // decoder stalls five cycles
        wait_valid(10);
        repeat (5) begin
            pcif.instr_ready = 1'b0;
            pcif.mem_rd_ack  = 1'($urandom);
            tick();
        end
        pcif.instr_ready = 1'b1;
        pcif.mem_rd_ack  = 1'b0;
        tick();

        // branch coinciding with ack
        wait_req(10);
        pcif.mem_rd_ack    = 1'b1;
        pcif.branch_taken  = 1'b1;
        pcif.branch_target = 16'h0200;
        pcif.instr_ready   = 1'b0;
        tick();
        pcif.branch_taken = 1'b0;
        chk("branch_mem_addr", 32'(pcif.mem_addr), 32'h0200);
        tick();
        pcif.mem_rd_ack  = 1'b0;
        pcif.instr_ready = 1'b1;
        tick();

        // halt while presenting, then everything ignored until reset
        wait_valid(10);
        pcif.halt = 1'b1;
        tick();
        pcif.halt = 1'b0;
        repeat (10) begin
            pcif.mem_rd_ack    = 1'b1;
            pcif.branch_taken  = 1'($urandom);
            pcif.branch_target = 16'($urandom);
            pcif.instr_ready   = 1'($urandom);
            tick();
        end
        idle();
        reset = 1'b1;
        tick();
        chk("rehalt_instr", 32'(pcif.instr), 32'h0);
        reset            = 1'b0;
        pcif.mem_rd_ack  = 1'b1;
        pcif.instr_ready = 1'b1;
        repeat (6) tick();

        // PC wrap at 0xFFFF
        wait_req(10);
        pcif.mem_rd_ack    = 1'b0;
        pcif.branch_taken  = 1'b1;
        pcif.branch_target = 16'hFFFF;
        tick();
        pcif.branch_taken = 1'b0;
        pcif.mem_rd_ack   = 1'b1;
        pcif.instr_ready  = 1'b0;
        tick();
        pcif.mem_rd_ack = 1'b0;
        chk("wrap_mem_addr", 32'(pcif.mem_addr), 32'h0000);
        pcif.instr_ready = 1'b1;
        tick();

        // reset during a wait state
        pcif.instr_ready = 1'b0;
        pcif.mem_rd_ack  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // randomized traffic
        rnd_mode = 1'b1;
        repeat (3000) begin
            reset              = ($urandom_range(199) == 0);
            pcif.halt          = ($urandom_range(299) == 0);
            pcif.branch_taken  = ($urandom_range(7) == 0);
            pcif.branch_target = 16'($urandom);
            pcif.mem_rd_ack    = 1'($urandom);
            pcif.instr_ready   = 1'($urandom);
            tick();
        end
        reset = 1'b0;
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
